// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side and RAM-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  // instruction cache (read-only)
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  // data cache (read/write)
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;
  // RAM port
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;

  // arbiter view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // caches + RAM view
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single RAM port arbiter, dcache priority with bounded icache starvation
module mem_arbiter #(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_e;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  state_e            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              d_req;
  logic              access;
  logic              icache_forced;
  logic [ADDR_W-1:0] addr_mux;
  logic [WORD_W-1:0] store_mux;
  logic              ren, wen, iwait_c, dwait_c;

  assign d_req         = bus.dREN | bus.dWEN;
  assign access        = (bus.ramstate == RAM_ACCESS);
  assign icache_forced = bus.iREN && (streak_q == STREAK_MAX);

  // load data is never registered: both caches see RAM data directly
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.ramREN   = ren;
  assign bus.ramWEN   = wen;
  assign bus.ramaddr  = addr_mux;
  assign bus.ramstore = store_mux;
  assign bus.iwait    = iwait_c;
  assign bus.dwait    = dwait_c;

  // grant decode: RAM controls, waits and next state/streak from current grant
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    ren       = 1'b0;
    wen       = 1'b0;
    addr_mux  = '0;
    store_mux = '0;
    iwait_c   = 1'b1;
    dwait_c   = 1'b1;
    case (state_q)
      IDLE: begin
        if (d_req && !icache_forced) begin
          state_d = DGNT;
        end else if (bus.iREN) begin
          state_d = IGNT;
        end
      end
      IGNT: begin
        addr_mux = bus.iaddr;
        if (!bus.iREN) begin
          // requester walked away: drop the RAM request, keep streak
          state_d = IDLE;
        end else begin
          ren = 1'b1;
          if (access) begin
            iwait_c  = 1'b0;
            state_d  = IDLE;
            streak_d = 4'd0;
          end
        end
      end
      DGNT: begin
        addr_mux = bus.daddr;
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          // a write wins when both dREN and dWEN are raised
          if (bus.dWEN) begin
            wen       = 1'b1;
            store_mux = bus.dstore;
          end else begin
            ren = 1'b1;
          end
          if (access) begin
            dwait_c = 1'b0;
            state_d = IDLE;
            if (!bus.iREN) begin
              streak_d = 4'd0;
            end else if (streak_q >= STREAK_MAX) begin
              streak_d = STREAK_MAX;
            end else begin
              streak_d = streak_q + 4'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // grant state and starvation streak registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int WORD_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int MAX_DSTREAK = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mem_arbiter_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .MAX_DSTREAK(MAX_DSTREAK)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    nrst = 1'b0;
    bus.ramload = 32'hA5A5_0F0F;
    #3;
    n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL reset_ramREN: got %0b want 0", bus.ramREN); end
    n_cmp++; if (bus.ramWEN !== 1'b0) begin n_fail++; $display("FAIL reset_ramWEN: got %0b want 0", bus.ramWEN); end
    n_cmp++; if (bus.ramaddr !== 32'd0) begin n_fail++; $display("FAIL reset_ramaddr: got %h want 0", bus.ramaddr); end
    n_cmp++; if (bus.ramstore !== 32'd0) begin n_fail++; $display("FAIL reset_ramstore: got %h want 0", bus.ramstore); end
    n_cmp++; if ({bus.iwait, bus.dwait} !== 2'b11) begin n_fail++; $display("FAIL reset_waits: got %b want 11", {bus.iwait, bus.dwait}); end
    n_cmp++; if (bus.iload !== 32'hA5A5_0F0F || bus.dload !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL reset_loads: got %h/%h want a5a50f0f", bus.iload, bus.dload); end
    tick(); tick();
    nrst = 1'b1;
    bus.ramload = '0;
  endtask

  task automatic test_icache_only();
    int lows = 0;
    idle_inputs();
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY; bus.ramload = 32'hDEAD_BEEF;
    #4;
    n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL icache_idle_ramREN: got %0b want 0", bus.ramREN); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.ramstate = (c == 3) ? ACCESS : BUSY;
      #4;
      if (c <= 3) begin
        n_cmp++; if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h40) begin
          n_fail++; $display("FAIL icache_req c%0d: got ren=%0b wen=%0b addr=%h want 1/0/40", c, bus.ramREN, bus.ramWEN, bus.ramaddr); end
      end else begin
        n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL icache_after_ramREN: got %0b want 0", bus.ramREN); end
      end
      n_cmp++; if (bus.iwait !== (c == 3 ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL icache_iwait c%0d: got %0b want %0b", c, bus.iwait, c != 3); end
      n_cmp++; if (bus.dwait !== 1'b1) begin n_fail++; $display("FAIL icache_dwait c%0d: got %0b want 1", c, bus.dwait); end
      if (bus.iwait === 1'b0) begin
        lows++;
        n_cmp++; if (bus.iload !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL icache_iload: got %h want deadbeef", bus.iload); end
      end
      if (c == 3) bus.iREN = 1'b0;
    end
    n_cmp++; if (lows != 1) begin n_fail++; $display("FAIL icache_wait_pulses: got %0d want 1", lows); end
    idle_inputs();
  endtask

  task automatic test_dcache_write();
    idle_inputs();
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h1234_5678; bus.ramstate = ACCESS;
    #4;
    n_cmp++; if (bus.ramWEN !== 1'b0 || bus.dwait !== 1'b1) begin n_fail++; $display("FAIL dwrite_idle: got wen=%0b dwait=%0b want 0/1", bus.ramWEN, bus.dwait); end
    tick(); #4;
    n_cmp++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL dwrite_ctl: got wen=%0b ren=%0b want 1/0", bus.ramWEN, bus.ramREN); end
    n_cmp++; if (bus.ramaddr !== 32'h100 || bus.ramstore !== 32'h1234_5678) begin n_fail++; $display("FAIL dwrite_bus: got addr=%h store=%h want 100/12345678", bus.ramaddr, bus.ramstore); end
    n_cmp++; if (bus.dwait !== 1'b0 || bus.iwait !== 1'b1) begin n_fail++; $display("FAIL dwrite_waits: got d=%0b i=%0b want 0/1", bus.dwait, bus.iwait); end
    tick(); #4;
    n_cmp++; if (bus.ramWEN !== 1'b0 || bus.dwait !== 1'b1) begin n_fail++; $display("FAIL dwrite_back_idle: got wen=%0b dwait=%0b want 0/1", bus.ramWEN, bus.dwait); end
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    idle_inputs();
    bus.iREN = 1'b1; bus.dREN = 1'b1; bus.ramstate = ACCESS;
    for (int k = 0; k < 10; k++) begin
      logic exp_i;
      exp_i = ((k % (MAX_DSTREAK + 1)) == MAX_DSTREAK);
      tick(); #4;
      n_cmp++; if ({bus.iwait, bus.dwait} !== (exp_i ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL contention_tx%0d: got iwait/dwait=%b want %b", k, {bus.iwait, bus.dwait}, exp_i ? 2'b01 : 2'b10); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_abort();
    idle_inputs();
    bus.iREN = 1'b1; bus.dREN = 1'b1; bus.ramstate = ACCESS;
    for (int k = 0; k < 3; k++) begin
      tick(); #4;
      n_cmp++; if (bus.dwait !== 1'b0) begin n_fail++; $display("FAIL abort_pre_d%0d: got dwait=%0b want 0", k, bus.dwait); end
      tick();
    end
    bus.ramstate = BUSY;
    tick(); #4;
    n_cmp++; if (bus.ramREN !== 1'b1 || bus.dwait !== 1'b1) begin n_fail++; $display("FAIL abort_granted: got ren=%0b dwait=%0b want 1/1", bus.ramREN, bus.dwait); end
    bus.dREN = 1'b0; #1;
    n_cmp++; if (bus.ramREN !== 1'b0 || bus.dwait !== 1'b1) begin n_fail++; $display("FAIL abort_drop: got ren=%0b dwait=%0b want 0/1", bus.ramREN, bus.dwait); end
    tick();
    n_cmp++; if (bus.ramREN !== 1'b0 || bus.dwait !== 1'b1 || bus.iwait !== 1'b1) begin n_fail++; $display("FAIL abort_idle: got ren=%0b d=%0b i=%0b want 0/1/1", bus.ramREN, bus.dwait, bus.iwait); end
    // three D completions before the abort; the abort must leave the count alone
    bus.dREN = 1'b1; bus.ramstate = ACCESS;
    tick(); #4;
    n_cmp++; if ({bus.iwait, bus.dwait} !== 2'b10) begin n_fail++; $display("FAIL abort_streak_d: got %b want 10", {bus.iwait, bus.dwait}); end
    tick(); tick(); #4;
    n_cmp++; if ({bus.iwait, bus.dwait} !== 2'b01) begin n_fail++; $display("FAIL abort_streak_i: got %b want 01", {bus.iwait, bus.dwait}); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_op();
    idle_inputs();
    bus.iREN = 1'b1; bus.dREN = 1'b1; bus.iaddr = 32'h8000; bus.ramstate = ACCESS;
    for (int k = 0; k < MAX_DSTREAK; k++) begin tick(); tick(); end
    bus.ramstate = BUSY;
    tick(); #4;
    n_cmp++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h8000 || bus.iwait !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_igrant: got ren=%0b addr=%h iwait=%0b want 1/8000/1", bus.ramREN, bus.ramaddr, bus.iwait); end
    #1 nrst = 1'b0; #1;
    n_cmp++; if (bus.ramREN !== 1'b0 || bus.ramaddr !== 32'd0 || {bus.iwait, bus.dwait} !== 2'b11) begin
      n_fail++; $display("FAIL rstmid_async: got ren=%0b addr=%h waits=%b want 0/0/11", bus.ramREN, bus.ramaddr, {bus.iwait, bus.dwait}); end
    bus.ramstate = ACCESS;
    tick(); #4;
    n_cmp++; if (bus.iwait !== 1'b1 || bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL rstmid_held: got iwait=%0b ren=%0b want 1/0", bus.iwait, bus.ramREN); end
    tick();
    nrst = 1'b1;
    tick(); #4;
    n_cmp++; if ({bus.iwait, bus.dwait} !== 2'b10) begin n_fail++; $display("FAIL rstmid_first_grant: got %b want 10", {bus.iwait, bus.dwait}); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_ram_error();
    idle_inputs();
    bus.dREN = 1'b1; bus.daddr = $urandom; bus.ramstate = ERROR; bus.ramload = $urandom;
    tick();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) bus.ramstate = ACCESS;
      #4;
      n_cmp++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== bus.daddr) begin
        n_fail++; $display("FAIL error_req c%0d: got ren=%0b addr=%h want 1/%h", c, bus.ramREN, bus.ramaddr, bus.daddr); end
      n_cmp++; if (bus.dwait !== (c == 3 ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL error_dwait c%0d: got %0b want %0b", c, bus.dwait, c != 3); end
      if (c == 3) begin
        n_cmp++; if (bus.dload !== bus.ramload) begin n_fail++; $display("FAIL error_dload: got %h want %h", bus.dload, bus.ramload); end
      end
      bus.dREN = (c != 3);
      tick();
    end
    #4;
    n_cmp++; if (bus.dwait !== 1'b1 || bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL error_after: got dwait=%0b ren=%0b want 1/0", bus.dwait, bus.ramREN); end
    idle_inputs();
    tick();
  endtask

  // transaction-level reference: who owns RAM and how many dcache completions
  // have gone by while the icache was kept waiting
  task automatic test_random();
    int owner = 0;      // 0 nobody, 1 icache, 2 dcache
    int dstreak = 0;
    int errs = 0;
    idle_inputs();
    nrst = 1'b0; tick(); nrst = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic dreq, done, in_rst;
      logic e_ren, e_wen, e_iw, e_dw;
      logic [ADDR_W-1:0] e_addr;
      logic [WORD_W-1:0] e_store;
      bus.iREN     = ($urandom_range(0, 9) < 7);
      bus.dREN     = ($urandom_range(0, 9) < 5);
      bus.dWEN     = ($urandom_range(0, 9) < 3);
      bus.iaddr    = $urandom; bus.daddr = $urandom;
      bus.dstore   = $urandom; bus.ramload = $urandom;
      bus.ramstate = ($urandom_range(0, 1) == 1) ? ACCESS : 2'($urandom_range(0, 3));
      in_rst = ($urandom_range(0, 79) == 0);
      nrst = !in_rst;
      #4;
      dreq = bus.dREN | bus.dWEN;
      done = (bus.ramstate == ACCESS);
      e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0; e_iw = 1; e_dw = 1;
      if (in_rst) begin
        owner = 0; dstreak = 0;
      end else if (owner == 1) begin
        e_addr = bus.iaddr;
        e_ren  = bus.iREN;
        e_iw   = !(bus.iREN && done);
        if (bus.iREN && done) dstreak = 0;
        owner = 0 + ((bus.iREN && !done) ? 1 : 0);
      end else if (owner == 2) begin
        e_addr  = bus.daddr;
        e_wen   = bus.dWEN;
        e_ren   = bus.dREN && !bus.dWEN;
        e_store = bus.dWEN ? bus.dstore : '0;
        e_dw    = !(dreq && done);
        if (dreq && done) dstreak = bus.iREN ? ((dstreak + 1 > MAX_DSTREAK) ? MAX_DSTREAK : dstreak + 1) : 0;
        owner = (dreq && !done) ? 2 : 0;
      end else begin
        if (dreq && !(bus.iREN && dstreak == MAX_DSTREAK)) owner = 2;
        else if (bus.iREN) owner = 1;
      end
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== {e_ren, e_wen, e_iw, e_dw} ||
          bus.ramaddr !== e_addr || bus.ramstore !== e_store ||
          bus.iload !== bus.ramload || bus.dload !== bus.ramload) begin
        n_fail++; errs++;
        if (errs <= 10)
          $display("FAIL random_cyc%0d: got ren/wen/iw/dw=%b addr=%h store=%h want %b addr=%h store=%h",
                   cyc, {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, bus.ramaddr, bus.ramstore,
                   {e_ren, e_wen, e_iw, e_dw}, e_addr, e_store);
      end
      tick();
    end
    nrst = 1'b1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_icache_only();
    test_dcache_write();
    test_contention();
    test_abort();
    test_reset_mid_op();
    test_ram_error();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
